// File: rtl/pe_result_drain.sv
// Result buffer behind pe_array: captures 2x16x16-bit blocks into a small FIFO and drains
// each block as two 256-bit row beats over a valid/ready stream.
module pe_result_drain #(
   parameter int unsigned DEPTH = 2,
   parameter int unsigned LW    = $clog2(DEPTH + 1)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [1:0][15:0][15:0]  pe_array_out,
   input  logic                    rounder_valid,
   input  logic [3:0]              round_number,
   output logic [255:0]            out_data,
   output logic                    out_row,
   output logic [3:0]              out_round,
   output logic                    out_last,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic [LW-1:0]           fill_level,
   output logic                    overflow,
   input  logic                    clr_overflow
);

   localparam int unsigned PW = $clog2(DEPTH);

   typedef logic [1:0][15:0][15:0] block_t;

   block_t        mem_q [DEPTH];
   logic [3:0]    tag_q [DEPTH];

   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [LW-1:0] count_q, count_d;
   logic          beat_q, beat_d;
   logic          overflow_q, overflow_d;

   logic          not_empty;
   logic          xfer;
   logic          pop;
   logic          push;
   logic          drop;

   always_comb begin
      not_empty = (count_q != '0);
      xfer      = not_empty & out_ready;
      pop       = xfer & beat_q;
      // A full FIFO still takes the new block when the head leaves on the same edge.
      push      = rounder_valid & ((count_q != LW'(DEPTH)) | pop);
      drop      = rounder_valid & ~push;

      wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
      rd_ptr_d  = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

      count_d   = count_q;
      if (push && !pop) begin
         count_d = count_q + LW'(1);
      end else if (pop && !push) begin
         count_d = count_q - LW'(1);
      end

      beat_d     = xfer ? ~beat_q : beat_q;
      overflow_d = drop | (overflow_q & ~clr_overflow);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         beat_q     <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         beat_q     <= beat_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is not reset; outputs are gated to zero while the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= pe_array_out;
         tag_q[wr_ptr_q] <= round_number;
      end
   end

   always_comb begin
      out_valid  = not_empty;
      out_row    = beat_q;
      out_last   = beat_q;
      out_data   = not_empty ? mem_q[rd_ptr_q][beat_q] : '0;
      out_round  = not_empty ? tag_q[rd_ptr_q] : '0;
      fill_level = count_q;
      overflow   = overflow_q;
   end

endmodule

// File: tb/tb_pe_result_drain.sv
// Self-checking bench for pe_result_drain: vector table, hand sequences and a randomized run
// against a queue-based reference model.
module tb_pe_result_drain;

   localparam int DEPTH = 2;
   localparam int LW    = $clog2(DEPTH + 1);

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [1:0][15:0][15:0] pe_array_out;
   logic                   rounder_valid;
   logic [3:0]             round_number;
   logic [255:0]           out_data;
   logic                   out_row;
   logic [3:0]             out_round;
   logic                   out_last;
   logic                   out_valid;
   logic                   out_ready;
   logic [LW-1:0]          fill_level;
   logic                   overflow;
   logic                   clr_overflow;

   always #5 clk = ~clk;

   pe_result_drain #(
      .DEPTH(DEPTH),
      .LW   (LW)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .pe_array_out (pe_array_out),
      .rounder_valid(rounder_valid),
      .round_number (round_number),
      .out_data     (out_data),
      .out_row      (out_row),
      .out_round    (out_round),
      .out_last     (out_last),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .fill_level   (fill_level),
      .overflow     (overflow),
      .clr_overflow (clr_overflow)
   );

   typedef struct {
      logic [511:0] d;
      logic [3:0]   t;
   } blk_t;

   // Reference model: list of stored blocks, which row of the head is on offer, sticky flag.
   blk_t mq[$];
   bit   mbeat;
   bit   movf;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [511:0] pat(input logic [3:0] tag);
      logic [1:0][15:0][15:0] b;
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 16; c++)
            b[r][c] = 16'((int'(tag) << 8) + r * 16 + c);
      return b;
   endfunction

   function automatic logic [511:0] rnd512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom;
      return v;
   endfunction

   function automatic logic [255:0] row_of(input logic [511:0] d, input bit r);
      return r ? d[511:256] : d[255:0];
   endfunction

   task automatic model_check();
      blk_t h;
      chk("m_valid", 256'(out_valid), 256'(mq.size() != 0));
      chk("m_fill", 256'(fill_level), 256'(mq.size()));
      chk("m_overflow", 256'(overflow), 256'(movf));
      if (mq.size() != 0) begin
         h = mq[0];
         chk("m_row", 256'(out_row), 256'(mbeat));
         chk("m_last", 256'(out_last), 256'(mbeat));
         chk("m_round", 256'(out_round), 256'(h.t));
         chk("m_data", out_data, row_of(h.d, mbeat));
      end else begin
         chk("m_data_empty", out_data, 256'(0));
      end
   endtask

   // Check current outputs against the model, apply inputs, advance the model and one clock.
   task automatic cycle(input bit rv, input logic [511:0] d, input logic [3:0] tag,
                        input bit rdy, input bit clr);
      bit   pop;
      bit   acc;
      blk_t b;
      model_check();
      rounder_valid = rv;
      pe_array_out  = d;
      round_number  = tag;
      out_ready     = rdy;
      clr_overflow  = clr;
      pop = (mq.size() != 0) && rdy && mbeat;
      acc = rv && ((mq.size() < DEPTH) || pop);
      if (mq.size() != 0 && rdy) begin
         if (mbeat) begin
            void'(mq.pop_front());
            mbeat = 1'b0;
         end else begin
            mbeat = 1'b1;
         end
      end
      if (acc) begin
         b.d = d;
         b.t = tag;
         mq.push_back(b);
      end
      if (rv && !acc) movf = 1'b1;
      else if (clr) movf = 1'b0;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_valid"}, 256'(out_valid), 256'(0));
      chk({tag, "_row"}, 256'(out_row), 256'(0));
      chk({tag, "_last"}, 256'(out_last), 256'(0));
      chk({tag, "_round"}, 256'(out_round), 256'(0));
      chk({tag, "_data"}, out_data, 256'(0));
      chk({tag, "_fill"}, 256'(fill_level), 256'(0));
      chk({tag, "_overflow"}, 256'(overflow), 256'(0));
   endtask

   typedef struct {
      bit            rv;
      logic [3:0]    tag;
      bit            rdy;
      bit            clr;
      bit            v;
      bit            row;
      logic [3:0]    rnd;
      logic [LW-1:0] fill;
      bit            ovf;
   } vec_t;

   vec_t tbl[16];

   initial begin
      logic [511:0] p;
      logic [511:0] d0;
      logic [255:0] held;

      // inputs: rv tag rdy clr | expected after edge: valid row round fill overflow
      tbl[0]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, LW'(1), 1'b0};
      tbl[1]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, LW'(2), 1'b0};
      tbl[2]  = '{1'b1, 4'd3, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, LW'(2), 1'b1};
      tbl[3]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, LW'(2), 1'b1};
      tbl[4]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, LW'(1), 1'b1};
      tbl[5]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, LW'(1), 1'b1};
      tbl[6]  = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, LW'(0), 1'b1};
      tbl[7]  = '{1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0, LW'(0), 1'b0};
      tbl[8]  = '{1'b1, 4'd1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, LW'(1), 1'b0};
      tbl[9]  = '{1'b1, 4'd2, 1'b0, 1'b0, 1'b1, 1'b0, 4'd1, LW'(2), 1'b0};
      tbl[10] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd1, LW'(2), 1'b0};
      tbl[11] = '{1'b1, 4'd3, 1'b1, 1'b0, 1'b1, 1'b0, 4'd2, LW'(2), 1'b0};
      tbl[12] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd2, LW'(2), 1'b0};
      tbl[13] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b0, 4'd3, LW'(1), 1'b0};
      tbl[14] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 4'd3, LW'(1), 1'b0};
      tbl[15] = '{1'b0, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 4'd0, LW'(0), 1'b0};

      rst_n         = 1'b0;
      pe_array_out  = '0;
      rounder_valid = 1'b0;
      round_number  = '0;
      out_ready     = 1'b0;
      clr_overflow  = 1'b0;
      mq.delete();
      mbeat = 1'b0;
      movf  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Single block, consumer always ready.
      for (int r = 0; r < 2; r++)
         for (int c = 0; c < 16; c++)
            d0[r*256 + c*16 +: 16] = 16'(r * 16 + c);
      cycle(1'b1, d0, 4'd5, 1'b1, 1'b0);
      chk("single_v0", 256'(out_valid), 256'(1));
      chk("single_row0", 256'(out_row), 256'(0));
      chk("single_last0", 256'(out_last), 256'(0));
      chk("single_round0", 256'(out_round), 256'(5));
      chk("single_data0", out_data, d0[255:0]);
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk("single_v1", 256'(out_valid), 256'(1));
      chk("single_row1", 256'(out_row), 256'(1));
      chk("single_last1", 256'(out_last), 256'(1));
      chk("single_round1", 256'(out_round), 256'(5));
      chk("single_data1", out_data, d0[511:256]);
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk("single_fill_end", 256'(fill_level), 256'(0));
      chk("single_valid_end", 256'(out_valid), 256'(0));

      // Back-pressure hold for 10 cycles.
      cycle(1'b1, pat(4'd9), 4'd9, 1'b0, 1'b0);
      held = out_data;
      chk("hold_first_data", held, row_of(pat(4'd9), 1'b0));
      for (int i = 0; i < 10; i++) begin
         cycle(1'b0, '0, 4'd0, 1'b0, 1'b0);
         chk("hold_valid", 256'(out_valid), 256'(1));
         chk("hold_row", 256'(out_row), 256'(0));
         chk("hold_data", out_data, held);
      end
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk("hold_rel_row", 256'(out_row), 256'(1));
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk("hold_rel_fill", 256'(fill_level), 256'(0));

      // Overflow, clear and full-with-pop vectors.
      for (int i = 0; i < 16; i++) begin
         cycle(tbl[i].rv, pat(tbl[i].tag), tbl[i].tag, tbl[i].rdy, tbl[i].clr);
         chk("t_valid", 256'(out_valid), 256'(tbl[i].v));
         chk("t_fill", 256'(fill_level), 256'(tbl[i].fill));
         chk("t_overflow", 256'(overflow), 256'(tbl[i].ovf));
         if (tbl[i].v) begin
            p = pat(tbl[i].rnd);
            chk("t_row", 256'(out_row), 256'(tbl[i].row));
            chk("t_round", 256'(out_round), 256'(tbl[i].rnd));
            chk("t_data", out_data, row_of(p, tbl[i].row));
         end
      end

      // Reset between row 0 and row 1 with another block queued.
      cycle(1'b1, pat(4'd7), 4'd7, 1'b0, 1'b0);
      cycle(1'b1, pat(4'd8), 4'd8, 1'b0, 1'b0);
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk("pre_rst_row", 256'(out_row), 256'(1));
      rst_n = 1'b0;
      #1;
      check_all_zero("mid_rst");
      mq.delete();
      mbeat = 1'b0;
      movf  = 1'b0;
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      chk("post_rst_valid", 256'(out_valid), 256'(0));
      cycle(1'b1, pat(4'd4), 4'd4, 1'b0, 1'b0);
      chk("post_rst_row", 256'(out_row), 256'(0));
      chk("post_rst_round", 256'(out_round), 256'(4));
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);
      cycle(1'b0, '0, 4'd0, 1'b1, 1'b0);

      // Pointer wrap: 20 blocks every 16 cycles, ready toggling every cycle.
      for (int k = 0; k < 20; k++)
         for (int j = 0; j < 16; j++)
            cycle(j == 0, rnd512(), 4'(k % 16), (j % 2) == 0, 1'b0);
      chk("wrap_overflow", 256'(overflow), 256'(0));
      chk("wrap_fill", 256'(fill_level), 256'(0));

      // Randomized traffic with bursts of back-pressure.
      for (int i = 0; i < 3000; i++)
         cycle($urandom_range(0, 3) == 0, rnd512(), 4'($urandom), $urandom_range(0, 2) != 0,
               $urandom_range(0, 15) == 0);
      model_check();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/pe_result_drain.md
# pe_result_drain

Output buffer directly downstream of `pe_array`. Captures the 2×16×16-bit result block each time `pe_array` asserts `rounder_valid`, tagged with its `round_number`, into a small FIFO. Drains each block as two 256-bit row beats over a valid/ready stream to the write-back path. Flags lost blocks when the FIFO overflows.

## Interface
Parameters:
- `DEPTH`, 2: number of buffered result blocks; power of two, ≥2.
- `LW`, `$clog2(DEPTH+1)`: width of `fill_level`.

Ports:
- `clk`  in  1  single clock, all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `pe_array_out`  in  [1:0][15:0][15:0]  result block from `pe_array`; index [row][col].
- `rounder_valid`  in  1  block on `pe_array_out` is final; capture this cycle.
- `round_number`  in  4  tag of the block, sampled together with the data.
- `out_data`  out  256  one row of 16×16-bit words; col 15 in bits [255:240].
- `out_row`  out  1  row index of the current beat (0 or 1).
- `out_round`  out  4  tag of the block being drained.
- `out_last`  out  1  high on the row-1 beat.
- `out_valid`  out  1  beat present.
- `out_ready`  in  1  consumer accepts the beat.
- `fill_level`  out  LW  number of blocks stored, including the one draining.
- `overflow`  out  1  sticky: a block was dropped.
- `clr_overflow`  in  1  synchronous clear of `overflow`.

## Operation
- Storage: `DEPTH` entries of {512-bit block, 4-bit tag}. The FIFO has write and read pointers modulo `DEPTH` and a count from 0 to `DEPTH`.
- Push: on each cycle with `rounder_valid`=1, write {pe_array_out, round_number} at the write pointer, then increment the pointer and count. Push is accepted when count<`DEPTH`, or when count=`DEPTH` and a pop completes in the same cycle.
- Drop: if `rounder_valid`=1 and the push is not accepted, discard the block, keep the FIFO unchanged and set `overflow`=1.
- `clr_overflow`=1 clears `overflow`. If a drop occurs in the same cycle, set wins and `overflow`=1.
- Drain uses a one-bit beat counter `beat`:
  - `out_valid` = (count≠0).
  - `out_row` = `beat`; `out_last` = `beat`.
  - `out_data` = head block row `beat`; `out_round` = head tag.
- Handshake: a beat transfers when `out_valid` & `out_ready`.
  - Transfer with `beat`=0: set `beat` to 1.
  - Transfer with `beat`=1: pop the head (increment read pointer, decrement count) and set `beat` to 0.
- Simultaneous push and pop leaves count unchanged; both pointers advance.
- `fill_level` = count.
- Output behaviour: outputs are registered or driven directly from storage, with no combinational path from `rounder_valid` to `out_*`. While `out_valid`=1 and `out_ready`=0, `out_data`, `out_row`, `out_round` and `out_last` hold stable.
- Any value of `round_number` is accepted; tags need not be sequential.

## Timing
- Reset (`rst_n`=0, asynchronous):
  - count, pointers and `beat` go to 0.
  - `out_valid`=0, `out_last`=0, `out_row`=0, `out_round`=0, `out_data`=0, `fill_level`=0, `overflow`=0.
  - Storage contents need not be reset, but `out_data` must read 0 while empty.
- Reset mid-drain discards all blocks. The first beat after release always has `out_row`=0.
- Latency:
  - A block pushed at edge N into an empty FIFO gives `out_valid`=1 with row 0 after edge N.
  - With `out_ready` held at 1, row 1 appears after edge N+1 and the entry pops at edge N+2.
- Sustained throughput is one block per 2 cycles. `pe_array` produces at most one block per 16 cycles, so overflow only occurs under long back-pressure.
- The full-and-pop case (count=`DEPTH`, row-1 transfer, `rounder_valid`=1 in the same cycle) must accept the push with no drop.

## Test plan
- Single block, `out_ready`=1:
  - Stimulus: one `rounder_valid` pulse with row0 col c = c, row1 col c = 16+c, `round_number`=5.
  - Response: two beats on consecutive cycles, {row 0, data word c=c, last=0} then {row 1, word c=16+c, last=1}, `out_round`=5 both beats; `fill_level` returns 0.
- Back-pressure hold:
  - Stimulus: `out_ready`=0 for 10 cycles after a push.
  - Response: `out_valid`=1, `out_row`=0, data stable for all 10 cycles; releasing `out_ready` gives 2 beats.
- Overflow:
  - Stimulus: `out_ready`=0, three pushes with tags 1, 2, 3 (`DEPTH`=2).
  - Response: `fill_level`=2 and `overflow`=1 after the third push; drain yields tags 1 then 2 only.
  - Then pulse `clr_overflow`: `overflow`=0.
- Full with simultaneous pop:
  - Stimulus: FIFO full (tags 1, 2); a push with tag 3 in the same cycle as the row-1 transfer of tag 1.
  - Response: no overflow, `fill_level` stays 2, drain order is 1, 2, 3.
- Reset mid-drain:
  - Stimulus: assert `rst_n`=0 between row 0 and row 1 of a block with 1 more block queued.
  - Response: all outputs 0 immediately; after release `out_valid`=0 until the next push.
- Pointer wrap:
  - Stimulus: 20 blocks, tags 0..15 then 0..3, pushed every 16 cycles with `out_ready` toggling 1/0 each cycle.
  - Response: all 20 drained in order with correct rows and `overflow`=0.
